// File: rtl/ps2_keyboard_pkg.sv
// Shared scancode constants, receiver bit positions and the matrix key
// position type used by the PS/2 keyboard front end.
package ps2_keyboard_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_E1    = 8'hE1;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_OVR0  = 8'h00;
  localparam logic [7:0] SC_OVR1  = 8'hFF;
  localparam logic [7:0] SC_F11   = 8'h78;
  localparam logic [7:0] SC_DEL   = 8'h71;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_ALT   = 8'h11;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_KP5   = 8'h73;
  localparam logic [7:0] SC_KP0   = 8'h70;

  // Receiver bit index of the parity and stop bits within an 11-bit frame.
  localparam logic [3:0] RX_PARITY = 4'd9;
  localparam logic [3:0] RX_STOP   = 4'd10;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t key_pos(input logic [2:0] r, input logic [2:0] c);
    return {1'b1, r, c};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx.sv
// PS/2 receiver: pin synchronisers, clock glitch filter and 11-bit frame
// assembly with odd parity, stop and inter-bit timeout checks.
module ps2_rx
  import ps2_keyboard_pkg::*;
#(
  parameter int FILTER_LEN = 16,
  parameter int TIMEOUT    = 56000
) (
  input  logic       rst_n,
  input  logic       clk28,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] rx_byte
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d, byte_q, byte_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          valid_q, valid_d;
  logic          fall, dat_bit;

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    dat_bit    = dat_sync_q[1];

    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    if (clk_sync_q[1] == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_d     = clk_sync_q[1];
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall = filt_q & ~filt_d;

    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    idle_d    = idle_q;
    if (fall) begin
      idle_d = '0;
      if (bit_cnt_q == 4'd0) begin
        if (!dat_bit) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q < RX_PARITY) begin
        shift_d   = {dat_bit, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == RX_PARITY) begin
        // Odd parity: data plus parity bit carry an odd number of ones.
        bit_cnt_d = (^{dat_bit, shift_q}) ? RX_STOP : 4'd0;
      end else begin
        bit_cnt_d = 4'd0;
        if (dat_bit) begin
          valid_d = 1'b1;
          byte_d  = shift_q;
        end
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == TW'(TIMEOUT - 1)) begin
        bit_cnt_d = 4'd0;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      byte_q     <= 8'h00;
      idle_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      idle_q     <= idle_d;
      valid_q    <= valid_d;
    end
  end

  assign byte_valid = valid_q;
  assign rx_byte    = byte_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard to ZX Spectrum 8x5 matrix, magic key and Ctrl+Alt+Del.
// Define PS2_JOY_EN to map the numpad onto a Kempston joystick output.
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int FILTER_LEN = 16,
  parameter int TIMEOUT    = 56000
) (
  input  logic       rst_n,
  input  logic       clk28,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] addr_hi,
  output logic [4:0] kd,
  output logic       key_magic,
  output logic       key_reset,
  output logic [7:0] joy
);

  function automatic key_pos_t lookup(input logic ext, input logic [7:0] code);
    key_pos_t p;
    p = '0;
    if (ext) begin
      if (code == SC_CTRL) p = key_pos(3'd7, 3'd1);
    end else begin
      case (code)
        8'h12, 8'h59: p = key_pos(3'd0, 3'd0);
        8'h1A: p = key_pos(3'd0, 3'd1);  8'h22: p = key_pos(3'd0, 3'd2);
        8'h21: p = key_pos(3'd0, 3'd3);  8'h2A: p = key_pos(3'd0, 3'd4);
        8'h1C: p = key_pos(3'd1, 3'd0);  8'h1B: p = key_pos(3'd1, 3'd1);
        8'h23: p = key_pos(3'd1, 3'd2);  8'h2B: p = key_pos(3'd1, 3'd3);
        8'h34: p = key_pos(3'd1, 3'd4);
        8'h15: p = key_pos(3'd2, 3'd0);  8'h1D: p = key_pos(3'd2, 3'd1);
        8'h24: p = key_pos(3'd2, 3'd2);  8'h2D: p = key_pos(3'd2, 3'd3);
        8'h2C: p = key_pos(3'd2, 3'd4);
        8'h16: p = key_pos(3'd3, 3'd0);  8'h1E: p = key_pos(3'd3, 3'd1);
        8'h26: p = key_pos(3'd3, 3'd2);  8'h25: p = key_pos(3'd3, 3'd3);
        8'h2E: p = key_pos(3'd3, 3'd4);
        8'h45: p = key_pos(3'd4, 3'd0);  8'h46: p = key_pos(3'd4, 3'd1);
        8'h3E: p = key_pos(3'd4, 3'd2);  8'h3D: p = key_pos(3'd4, 3'd3);
        8'h36: p = key_pos(3'd4, 3'd4);
        8'h4D: p = key_pos(3'd5, 3'd0);  8'h44: p = key_pos(3'd5, 3'd1);
        8'h43: p = key_pos(3'd5, 3'd2);  8'h3C: p = key_pos(3'd5, 3'd3);
        8'h35: p = key_pos(3'd5, 3'd4);
        8'h5A: p = key_pos(3'd6, 3'd0);  8'h4B: p = key_pos(3'd6, 3'd1);
        8'h42: p = key_pos(3'd6, 3'd2);  8'h3B: p = key_pos(3'd6, 3'd3);
        8'h33: p = key_pos(3'd6, 3'd4);
        8'h29: p = key_pos(3'd7, 3'd0);  8'h14: p = key_pos(3'd7, 3'd1);
        8'h3A: p = key_pos(3'd7, 3'd2);  8'h31: p = key_pos(3'd7, 3'd3);
        8'h32: p = key_pos(3'd7, 3'd4);
        default: p = '0;
      endcase
    end
    return p;
  endfunction

  logic       byte_valid;
  logic [7:0] rx_byte;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
    .rst_n      (rst_n),
    .clk28      (clk28),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte)
  );

  // comp: 0 backspace, 1 left, 2 down, 3 up, 4 right; ctrl/alt: 0 left, 1 right.
  logic [7:0][4:0] keys_q, keys_d, mat;
  logic [4:0]      comp_q, comp_d;
  logic [1:0]      ctrl_q, ctrl_d, alt_q, alt_d;
  logic            magic_q, magic_d, del_q, del_d, reset_q, reset_d;
  logic            ext_q, ext_d, rel_q, rel_d;
  logic [2:0]      pause_q, pause_d;
  key_pos_t        pos;
`ifdef PS2_JOY_EN
  logic [4:0]      joy_q, joy_d;
`endif

  always_comb begin
    keys_d  = keys_q;
    comp_d  = comp_q;
    ctrl_d  = ctrl_q;
    alt_d   = alt_q;
    magic_d = magic_q;
    del_d   = del_q;
    reset_d = 1'b0;
    ext_d   = ext_q;
    rel_d   = rel_q;
    pause_d = pause_q;
`ifdef PS2_JOY_EN
    joy_d   = joy_q;
`endif
    pos     = lookup(ext_q, rx_byte);
    if (byte_valid) begin
      if (pause_q != 3'd0) begin
        pause_d = pause_q - 3'd1;
      end else if (rx_byte == SC_E0) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_F0) begin
        rel_d = 1'b1;
      end else if (rx_byte == SC_E1) begin
        pause_d = 3'd7;
      end else if (rx_byte == SC_BAT || rx_byte == SC_OVR0 || rx_byte == SC_OVR1) begin
        keys_d  = '0;
        comp_d  = '0;
        ctrl_d  = '0;
        alt_d   = '0;
        magic_d = 1'b0;
        del_d   = 1'b0;
        ext_d   = 1'b0;
        rel_d   = 1'b0;
`ifdef PS2_JOY_EN
        joy_d   = '0;
`endif
      end else begin
        if (pos.valid) keys_d[pos.row][pos.col] = ~rel_q;
        if (!ext_q) begin
          case (rx_byte)
            SC_BKSP: comp_d[0]  = ~rel_q;
            SC_F11:  magic_d    = ~rel_q;
            SC_CTRL: ctrl_d[0]  = ~rel_q;
            SC_ALT:  alt_d[0]   = ~rel_q;
`ifdef PS2_JOY_EN
            SC_RIGHT:        joy_d[0] = ~rel_q;
            SC_LEFT:         joy_d[1] = ~rel_q;
            SC_DOWN:         joy_d[2] = ~rel_q;
            SC_UP:           joy_d[3] = ~rel_q;
            SC_KP5, SC_KP0:  joy_d[4] = ~rel_q;
`endif
            default: ;
          endcase
        end else begin
          case (rx_byte)
            SC_LEFT:  comp_d[1] = ~rel_q;
            SC_DOWN:  comp_d[2] = ~rel_q;
            SC_UP:    comp_d[3] = ~rel_q;
            SC_RIGHT: comp_d[4] = ~rel_q;
            SC_CTRL:  ctrl_d[1] = ~rel_q;
            SC_ALT:   alt_d[1]  = ~rel_q;
            SC_DEL: begin
              // del_q blocks typematic repeats until Del is released.
              if (!rel_q && !del_q && (|ctrl_q) && (|alt_q)) reset_d = 1'b1;
              del_d = ~rel_q;
            end
            default: ;
          endcase
        end
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      keys_q  <= '0;
      comp_q  <= '0;
      ctrl_q  <= '0;
      alt_q   <= '0;
      magic_q <= 1'b0;
      del_q   <= 1'b0;
      reset_q <= 1'b0;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      pause_q <= 3'd0;
`ifdef PS2_JOY_EN
      joy_q   <= '0;
`endif
    end else begin
      keys_q  <= keys_d;
      comp_q  <= comp_d;
      ctrl_q  <= ctrl_d;
      alt_q   <= alt_d;
      magic_q <= magic_d;
      del_q   <= del_d;
      reset_q <= reset_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      pause_q <= pause_d;
`ifdef PS2_JOY_EN
      joy_q   <= joy_d;
`endif
    end
  end

  // Composite keys are ORed over the direct matrix so each keeps its own state.
  always_comb begin
    mat       = keys_q;
    mat[0][0] = keys_q[0][0] | (|comp_q);
    mat[4][0] = keys_q[4][0] | comp_q[0];
    mat[3][4] = keys_q[3][4] | comp_q[1];
    mat[4][4] = keys_q[4][4] | comp_q[2];
    mat[4][3] = keys_q[4][3] | comp_q[3];
    mat[4][2] = keys_q[4][2] | comp_q[4];
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_col
    logic [7:0] col;
    always_comb begin
      for (int r = 0; r < 8; r++) col[r] = mat[r][gi];
    end
    assign kd[gi] = ~|(col & ~addr_hi);
  end

  assign key_magic = magic_q;
  assign key_reset = reset_q;
`ifdef PS2_JOY_EN
  assign joy = {3'b000, joy_q};
`else
  assign joy = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: vector table, corner-case sequences
// and randomized key traffic checked against a key-set reference model.
module tb_ps2_keyboard;

  localparam int HALF = 22;
  localparam int TO   = 1500;
`ifdef PS2_JOY_EN
  localparam bit JOY = 1'b1;
`else
  localparam bit JOY = 1'b0;
`endif

  logic       rst_n;
  logic       clk28 = 1'b0;
  logic       ps2_clk, ps2_dat;
  logic [7:0] addr_hi;
  logic [4:0] kd;
  logic       key_magic, key_reset;
  logic [7:0] joy;

  int errors = 0;
  int checks = 0;
  int rst_pulses = 0;
  int rst_cycles = 0;
  logic key_reset_prev = 1'b0;

  always #5 clk28 = ~clk28;

  ps2_keyboard #(.FILTER_LEN(16), .TIMEOUT(TO)) dut (
    .rst_n     (rst_n),
    .clk28     (clk28),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .addr_hi   (addr_hi),
    .kd        (kd),
    .key_magic (key_magic),
    .key_reset (key_reset),
    .joy       (joy)
  );

  always @(negedge clk28) begin
    if (key_reset) begin
      rst_cycles <= rst_cycles + 1;
      if (!key_reset_prev) rst_pulses <= rst_pulses + 1;
    end
    key_reset_prev <= key_reset;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk28);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic check_kd(input string name, input logic [7:0] a, input logic [4:0] exp);
    @(negedge clk28);
    addr_hi = a;
    #1;
    check($sformatf("%s kd@%h", name, a), {27'd0, kd}, {27'd0, exp});
  endtask

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2;
    logic [7:0] addr;
    logic [4:0] kd;
  } vec_t;

  typedef struct {
    bit         ext;
    logic [7:0] code;
    int         r0, c0, r1, c1;
  } pool_t;

  vec_t  vecs[20];
  pool_t pool[20];
  bit    held[20];

  // Expected kd from the set of held keys and the key -> matrix position table.
  function automatic logic [4:0] model_kd(input logic [7:0] a);
    logic [4:0] k;
    k = 5'b11111;
    for (int i = 0; i < 20; i++) begin
      if (held[i]) begin
        if (pool[i].r0 < 8 && !a[pool[i].r0]) k[pool[i].c0] = 1'b0;
        if (pool[i].r1 < 8 && !a[pool[i].r1]) k[pool[i].c1] = 1'b0;
      end
    end
    return k;
  endfunction

  initial begin
    vecs[0]  = '{1, 8'h1C, 8'h00, 8'h00, 8'hFD, 5'b11110};
    vecs[1]  = '{2, 8'hF0, 8'h1C, 8'h00, 8'hFD, 5'b11111};
    vecs[2]  = '{1, 8'h66, 8'h00, 8'h00, 8'hFE, 5'b11110};
    vecs[3]  = '{0, 8'h00, 8'h00, 8'h00, 8'hEF, 5'b11110};
    vecs[4]  = '{1, 8'h12, 8'h00, 8'h00, 8'hFE, 5'b11110};
    vecs[5]  = '{2, 8'hF0, 8'h66, 8'h00, 8'hFE, 5'b11110};
    vecs[6]  = '{0, 8'h00, 8'h00, 8'h00, 8'hEF, 5'b11111};
    vecs[7]  = '{2, 8'hF0, 8'h12, 8'h00, 8'hFE, 5'b11111};
    vecs[8]  = '{1, 8'h16, 8'h00, 8'h00, 8'hF7, 5'b11110};
    vecs[9]  = '{1, 8'h1D, 8'h00, 8'h00, 8'hF3, 5'b11100};
    vecs[10] = '{0, 8'h00, 8'h00, 8'h00, 8'hFF, 5'b11111};
    vecs[11] = '{0, 8'h00, 8'h00, 8'h00, 8'hFB, 5'b11101};
    vecs[12] = '{2, 8'hF0, 8'h16, 8'h00, 8'hF3, 5'b11101};
    vecs[13] = '{2, 8'hF0, 8'h1D, 8'h00, 8'h00, 5'b11111};
    vecs[14] = '{2, 8'hE0, 8'h75, 8'h00, 8'hFE, 5'b11110};
    vecs[15] = '{0, 8'h00, 8'h00, 8'h00, 8'hEF, 5'b10111};
    vecs[16] = '{3, 8'hE0, 8'hF0, 8'h75, 8'h00, 5'b11111};
    vecs[17] = '{2, 8'hE0, 8'h74, 8'h00, 8'hEF, 5'b11011};
    vecs[18] = '{3, 8'hE0, 8'hF0, 8'h74, 8'h00, 5'b11111};
    vecs[19] = '{2, 8'hE0, 8'h14, 8'h00, 8'h7F, 5'b11101};

    pool[0]  = '{0, 8'h1C, 1, 0, 8, 0};
    pool[1]  = '{0, 8'h1B, 1, 1, 8, 0};
    pool[2]  = '{0, 8'h22, 0, 2, 8, 0};
    pool[3]  = '{0, 8'h29, 7, 0, 8, 0};
    pool[4]  = '{0, 8'h4D, 5, 0, 8, 0};
    pool[5]  = '{0, 8'h5A, 6, 0, 8, 0};
    pool[6]  = '{0, 8'h45, 4, 0, 8, 0};
    pool[7]  = '{0, 8'h2E, 3, 4, 8, 0};
    pool[8]  = '{0, 8'h12, 0, 0, 8, 0};
    pool[9]  = '{0, 8'h14, 7, 1, 8, 0};
    pool[10] = '{0, 8'h66, 0, 0, 4, 0};
    pool[11] = '{1, 8'h6B, 0, 0, 3, 4};
    pool[12] = '{1, 8'h72, 0, 0, 4, 4};
    pool[13] = '{1, 8'h75, 0, 0, 4, 3};
    pool[14] = '{1, 8'h74, 0, 0, 4, 2};
    pool[15] = '{0, 8'h78, 8, 0, 8, 0};
    pool[16] = '{0, 8'h75, 8, 0, 8, 0};
    pool[17] = '{0, 8'h73, 8, 0, 8, 0};
    pool[18] = '{0, 8'h72, 8, 0, 8, 0};
    pool[19] = '{0, 8'h36, 4, 4, 8, 0};
    for (int i = 0; i < 20; i++) held[i] = 1'b0;

    rst_n   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    addr_hi = 8'h00;
    wait_clk(5);
    #1;
    check("reset kd", {27'd0, kd}, 32'h1F);
    check("reset key_magic", {31'd0, key_magic}, 32'd0);
    check("reset key_reset", {31'd0, key_reset}, 32'd0);
    check("reset joy", {24'd0, joy}, 32'd0);
    @(negedge clk28);
    rst_n = 1'b1;
    wait_clk(5);

    for (int v = 0; v < 20; v++) begin
      if (vecs[v].n > 0) send(vecs[v].b0);
      if (vecs[v].n > 1) send(vecs[v].b1);
      if (vecs[v].n > 2) send(vecs[v].b2);
      check_kd($sformatf("vec%0d", v), vecs[v].addr, vecs[v].kd);
    end
    send(8'hE0); send(8'hF0); send(8'h14);
    check_kd("rctrl release", 8'h7F, 5'b11111);

    // Bad parity, bad stop, and a partial frame abandoned by timeout.
    send_frame(8'h15, 1'b1, 1'b0, 11);
    check_kd("bad parity", 8'hFB, 5'b11111);
    send(8'h15);
    check_kd("good after bad parity", 8'hFB, 5'b11110);
    send(8'hF0); send(8'h15);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check_kd("bad stop", 8'hFD, 5'b11111);
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    wait_clk(TO + 200);
    send(8'h1B);
    check_kd("after timeout", 8'hFD, 5'b11101);
    send(8'hF0); send(8'h1B);
    check_kd("release S", 8'hFD, 5'b11111);

    // Ctrl+Alt+Del.
    send(8'h14); send(8'h11); send(8'hE0); send(8'h71);
    check("cad first", rst_pulses, 1);
    send(8'hE0); send(8'h71);
    check("cad typematic", rst_pulses, 1);
    send(8'hE0); send(8'hF0); send(8'h71);
    send(8'hE0); send(8'h71);
    check("cad second", rst_pulses, 2);
    check("cad pulse width", rst_cycles, 2);
    send(8'hF0); send(8'h14);
    send(8'hE0); send(8'hF0); send(8'h71);
    send(8'hE0); send(8'h71);
    check("del without ctrl", rst_pulses, 2);
    send(8'hF0); send(8'h11);
    send(8'hE0); send(8'hF0); send(8'h71);

    // Pause sequence is swallowed; BAT clears all.
    send(8'h1C);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check_kd("pause no ctrl", 8'h7F, 5'b11111);
    check_kd("pause A held", 8'hFD, 5'b11110);
    send(8'h12);
    send(8'hAA);
    check_kd("bat clear", 8'h00, 5'b11111);
    send(8'hE0); send(8'hAA); send(8'h12);
    check_kd("bat clears ext", 8'hFE, 5'b11110);
    send(8'hF0); send(8'h12);

    send(8'h78);
    #1 check("magic press", {31'd0, key_magic}, 32'd1);
    send(8'hF0); send(8'h78);
    #1 check("magic release", {31'd0, key_magic}, 32'd0);

    send(8'h75); send(8'h73);
    #1 check("joy up+fire", {24'd0, joy}, JOY ? 32'h18 : 32'h00);
    check_kd("joy no matrix", 8'h00, 5'b11111);
    send(8'hF0); send(8'h75); send(8'hF0); send(8'h73);
    #1 check("joy released", {24'd0, joy}, 32'd0);

    // Random key traffic against the held-key model.
    send(8'hAA);
    for (int e = 0; e < 40; e++) begin
      int  i;
      bit  pr;
      logic [7:0] a;
      logic [7:0] ej;
      i  = $urandom_range(0, 19);
      pr = 1'($urandom % 2);
      if (pool[i].ext) send(8'hE0);
      if (!pr) send(8'hF0);
      send(pool[i].code);
      held[i] = pr;
      a = 8'($urandom);
      check_kd($sformatf("rand%0d %s%h", e, pr ? "make " : "brk ", pool[i].code), a, model_kd(a));
      ej = JOY ? {3'b000, held[17], held[16], held[18], 2'b00} : 8'h00;
      check($sformatf("rand%0d magic", e), {31'd0, key_magic}, {31'd0, held[15]});
      check($sformatf("rand%0d joy", e), {24'd0, joy}, {24'd0, ej});
    end
    check("no stray reset", rst_pulses, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Converts a PS/2 keyboard (scancode set 2) into the 8x5 ZX Spectrum key matrix and drives the active-low kd[4:0] column lines consumed by the port #FE read logic.
- The matrix row is selected by CPU address bits A15..A8.
- Also produces the magic-button level and the Ctrl+Alt+Del reset request.
- Sits between the board PS/2 pins and the I/O port decoder.

Parameters:
- FILTER_LEN, 16: consecutive equal clk28 samples needed before the filtered PS/2 clock changes.
- TIMEOUT, 56000: clk28 cycles (~2 ms) without a PS/2 clock falling edge after which a partial frame is discarded.

Ports:
- rst_n  in  1  asynchronous, active-low reset.
- clk28  in  1  system clock, 28 MHz.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- addr_hi  in  8  CPU address A15..A8; row r selected when addr_hi[r]==0.
- kd  out  5  key columns, active-low; bit0 = outermost key.
- key_magic  out  1  F11 held (level).
- key_reset  out  1  one-clk28 pulse on Ctrl+Alt+Del.
- joy  out  8  Kempston-format joystick state (see optional feature).

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk28.
- Reset values: all matrix and composite bits 0, kd=5'b11111, key_magic=0, key_reset=0, joy=0, receiver and decoder idle.
- Input conditioning:
  - ps2_clk and ps2_dat pass through 2-flop synchronisers.
  - Filtered clock updates only after FILTER_LEN identical samples.
  - A data bit is sampled on each filtered falling edge.
- Receiver frame: start(0), 8 data bits LSB first, odd parity, stop(1).
  - Bad start, bad parity or stop=0: frame dropped silently, receiver returns to waiting for start.
  - TIMEOUT idle mid-frame: bit counter cleared.
  - Good frame: 1-cycle byte_valid strobe with the 8-bit code, issued on the clk28 after the stop-bit edge.
- Decoder state (flags ext, rel, pause_cnt[2:0]):
  - E0: set ext.
  - F0: set rel.
  - E1: pause_cnt=7; the next 7 bytes are dropped.
  - AA (BAT) or 00/FF (overrun): clear all keys and flags.
  - Any other byte: look up (ext, code), set the key bit (rel=0) or clear it (rel=1), then clear ext and rel.
  - Unmapped codes only clear the flags.
- Matrix (row = address bit, col 0..4):
  - r0 CS Z X C V; r1 A S D F G; r2 Q W E R T; r3 1 2 3 4 5; r4 0 9 8 7 6; r5 P O I U Y; r6 Enter L K J H; r7 Space SS M N B.
  - CS = L/R Shift (12/59). SS = L/R Ctrl (14, E0 14).
- Composite keys keep their own flags and are ORed in, so releasing a composite never clears a directly held key:
  - Backspace(66) = CS+0.
  - Arrows: left E0 6B = CS+5, down E0 72 = CS+6, up E0 75 = CS+7, right E0 74 = CS+8.
- Column output: kd[c] = ~OR over r of (key[r][c] & ~addr_hi[r]).
  - Combinational from registered state; zero clocks from an addr_hi change.
  - addr_hi=FF gives 11111. Multiple rows selected AND together (wired-AND).
- key_magic: follows F11 (78) press/release.
- key_reset: pulses once when Del (E0 71) make arrives while any Ctrl and any Alt (11 / E0 11) are held.
  - Typematic repeats of Del do not re-pulse until Del has been released.
- Typematic repeats of held keys: idempotent.

Optional Feature:
- Macro PS2_JOY_EN.
- Defined: numpad keys drive joy: bit0 right (74), bit1 left (6B), bit2 down (72), bit3 up (75), bit4 fire (numpad 5 = 73 or numpad 0 = 70). Non-extended codes only; these keys do not touch the matrix.
- Undefined: joy tied to 8'h00 and the numpad codes are unmapped.

Decomposition:
- Shared package common: scancode constants (SC_E0, SC_F0, SC_E1, SC_BAT, SC_F11, SC_DEL...) and typedef key_pos_t {valid, row[2:0], col[2:0]}.
- Sub-module ps2_rx: synchroniser, filter, frame/parity/timeout handling; outputs byte_valid and byte.
- The lookup function lives in ps2_keyboard.

Test Plan:
- Send 1C, then hold addr_hi=FD -> kd=11110; send F0 1C -> kd=11111.
- Send 66 (Backspace), addr_hi=FE -> kd=11110; addr_hi=EF -> kd=11110; send 12 then F0 66 -> row0 still 11110 (Shift still held).
- Frame with wrong parity for 15 -> no change; next valid 15 at addr_hi=FB -> kd=11110.
- Send 14, 11, E0 71 -> exactly one key_reset pulse; repeated E0 71 -> no further pulse; F0-prefixed release of Del then E0 71 again -> second pulse.
- Send E1 14 77 E1 F0 14 F0 77 -> matrix unchanged; send AA while keys are held -> all kd=11111.
- With PS2_JOY_EN defined: send 75, 73 -> joy=8'h18. With the macro undefined -> joy=8'h00.
